nios2_mult_pipe: RTL and testbench
==================================

Name: nios2_mult_pipe

Overview:
- Parametrised, handshaked successor to the fixed 32x32 low-half multiply cell in the Nios II datapath.
- Supports the full Nios II multiply family: MUL, MULXSS, MULXSU and MULXUU.
- Operand width and pipeline depth are configurable; data moves on a valid/ready handshake with a pass-through tag.
- Sits between the A-stage operand latch and the writeback mux; the tag carries the destination register index.

Parameters:
- DATA_W, 32, operand width in bits; full product is 2*DATA_W.
- PART_W, 16, partial-product slice width; DATA_W must be a multiple of PART_W.
- LATENCY, 3, pipeline stages from input accept to out_valid; legal range 2..6.
- TAG_W, 5, width of the side-band tag carried with each operation.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  2  00=MUL (low half), 01=MULXSS, 10=MULXSU (src1 signed, src2 unsigned), 11=MULXUU; 01..11 return the high half.
- in_src1  in  DATA_W  multiplicand.
- in_src2  in  DATA_W  multiplier.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  selected half of the product.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all stage valid bits 0; out_valid=0, out_result=0, out_tag=0.
  - in_ready is 1 in the first cycle after reset deasserts.
  - Reset asserted mid-operation discards every in-flight operation; no result is emitted for it.
- Pipeline advance: adv = ~out_valid | out_ready. in_ready = adv (combinational).
  - When adv=0 the whole pipe holds: data, tags and valid bits are all frozen.
  - Bubbles are not collapsed.
- Accept and emit: an operation is accepted when in_valid & in_ready. Its result appears with out_valid=1 exactly LATENCY advancing cycles later.
  - Back-to-back accepts with out_ready held 1 give one result per cycle, in order.
- Stage 0 (operand capture):
  - Capture src1, src2, op and tag.
  - Extend each operand to DATA_W+1 bits: src1 is sign-extended for ops 01 and 10; src2 is sign-extended for op 01; otherwise both are zero-extended.
- Stage 1 (partial products):
  - Split the operands into PART_W slices and form every slice product.
  - Form the signed correction terms for the extension bit.
- Stages 2..LATENCY-1 (reduction):
  - Adder-tree reduction of the partial products to a 2*DATA_W product.
  - Reduction is spread across these stages.
  - For LATENCY=2 the final sum is computed combinationally into the output register.
- Result select and width rules:
  - op 00 returns product[DATA_W-1:0]; ops 01..11 return product[2*DATA_W-1:DATA_W].
  - The full product is never truncated before selection.
  - MUL's low half is sign-independent.
- Output register:
  - Holds its value while out_valid & ~out_ready.
  - On a bubble with adv=1, out_valid drops to 0; out_result keeps its last value.
- Simultaneous accept and emit in the same cycle is legal and loses no data.
- Latency is independent of op and operand values; there is no early-out.

Optional Feature:
- Macro: NIOS2_MULT_PIPE_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 clears every stage valid bit, including out_valid, on the next clk edge, regardless of adv.
  - An operation presented with in_valid in the same cycle as flush is dropped.
  - in_ready is unaffected by flush.
- When undefined: no flush port; the pipe drains only through the handshake.

Test Plan:
- MUL 0xFFFFFFFF x 0xFFFFFFFF (DATA_W=32, LATENCY=3) -> out_result=0x00000001 three cycles after accept, out_tag=in_tag.
- Same operands through MULXUU -> 0xFFFFFFFE; MULXSS -> 0x00000000; MULXSU -> 0xFFFFFFFF.
- Stream 8 back-to-back MULXUU ops (0x00010000 x 0x00010000, tags 0..7) with out_ready=1 -> 8 consecutive results of 0x00000001 with tags 0..7, one per cycle, in order.
- Backpressure: hold out_ready=0 for 5 cycles while the pipe is full -> in_ready=0, out_result and out_tag stable throughout. Release -> no loss, no duplication.
- Assert reset for 1 cycle with 3 ops in flight -> out_valid=0 immediately; no stale results afterwards; the next op (MUL 7 x 6) returns 42.
- With NIOS2_MULT_PIPE_FLUSH_EN: flush one cycle after 2 accepts -> neither result is emitted; an op accepted the following cycle returns correctly after LATENCY cycles.

Source files
------------

// File: rtl/nios2_mult_pipe_if.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | nios2_mult_pipe_if                                                        |
// | Request/response handshake bundle for the pipelined Nios II multiplier.   |
// | Optional macro: NIOS2_MULT_PIPE_FLUSH_EN adds the flush strobe.           |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
interface nios2_mult_pipe_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        in_op;
   logic [DATA_W-1:0] in_src1;
   logic [DATA_W-1:0] in_src2;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_result;
   logic [TAG_W-1:0]  out_tag;
`ifdef NIOS2_MULT_PIPE_FLUSH_EN
   logic              flush;

   modport master (
      output in_valid, in_op, in_src1, in_src2, in_tag, out_ready, flush,
      input  in_ready, out_valid, out_result, out_tag
   );
   modport slave (
      input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready, flush,
      output in_ready, out_valid, out_result, out_tag
   );
`else
   modport master (
      output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
      input  in_ready, out_valid, out_result, out_tag
   );
   modport slave (
      input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
      output in_ready, out_valid, out_result, out_tag
   );
`endif
endinterface
`default_nettype wire

// File: rtl/nios2_mult_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | nios2_mult_pipe                                                           |
// | Handshaked, parametrised MUL/MULXSS/MULXSU/MULXUU pipeline with tag.      |
// | Optional macro: NIOS2_MULT_PIPE_FLUSH_EN (adds bus.flush).                |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module nios2_mult_pipe #(
   parameter int DATA_W  = 32,
   parameter int PART_W  = 16,
   parameter int LATENCY = 3,
   parameter int TAG_W   = 5
) (
   input  logic                clk,
   input  logic                reset,
   nios2_mult_pipe_if.slave    bus
);

   localparam int c_nslice = DATA_W / PART_W;
   localparam int c_nterm  = c_nslice * c_nslice + 1;
   localparam int c_nlev   = $clog2(c_nterm);
   localparam int c_npad   = 1 << c_nlev;
   localparam int c_pw     = 2 * DATA_W;
   localparam int c_nst    = LATENCY - 1;
   localparam int c_nred   = (LATENCY > 2) ? (LATENCY - 2) : 1;

   typedef logic [c_npad-1:0][c_pw-1:0] terms_t;

   if ((DATA_W % PART_W) != 0 || LATENCY < 2 || LATENCY > 6) begin : g_param_check
      $error("nios2_mult_pipe: illegal DATA_W/PART_W/LATENCY combination");
   end

   // Slice products of the low DATA_W bits plus one term that folds in the
   // extension bits: value = low - ext*2^DATA_W, and ext1*ext2*2^(2*DATA_W)
   // vanishes modulo the product width.
   function automatic terms_t f_pp(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic              aext,
                                   input logic              bext);
      terms_t              t;
      logic [2*PART_W-1:0] p;
      logic [DATA_W-1:0]   ca;
      logic [DATA_W-1:0]   cb;
      logic [DATA_W:0]     s;
      t = '0;
      for (int i = 0; i < c_nslice; i++) begin
         for (int j = 0; j < c_nslice; j++) begin
            p = a[i*PART_W +: PART_W] * b[j*PART_W +: PART_W];
            t[i*c_nslice + j] = (c_pw)'(p) << ((i + j) * PART_W);
         end
      end
      ca = aext ? b : '0;
      cb = bext ? a : '0;
      s  = {1'b0, ca} + {1'b0, cb};
      t[c_nterm-1] = '0 - {s[DATA_W-1:0], {DATA_W{1'b0}}};
      return t;
   endfunction

   function automatic terms_t f_reduce(input terms_t t, input int n);
      terms_t cur;
      terms_t nxt;
      cur = t;
      for (int l = 0; l < c_nlev; l++) begin
         if (l < n) begin
            nxt = '0;
            for (int i = 0; i < c_npad / 2; i++) begin
               nxt[i] = cur[2*i] + cur[2*i+1];
            end
            cur = nxt;
         end
      end
      return cur;
   endfunction

   // Tree levels completed once stage k has been registered.
   function automatic int f_done(input int k);
      return (c_nlev * (k - 1)) / c_nred;
   endfunction

   logic                w_adv;
   logic                w_flush;
   logic                w_aext;
   logic                w_bext;
   logic [c_pw-1:0]     w_product;
   logic [DATA_W-1:0]   w_sel;

   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic                r_aext;
   logic                r_bext;
   logic [c_nst-1:0]    r_v;
   logic [1:0]          r_op  [c_nst];
   logic [TAG_W-1:0]    r_tag [c_nst];
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_result;
   logic [TAG_W-1:0]    r_out_tag;

`ifdef NIOS2_MULT_PIPE_FLUSH_EN
   assign w_flush = bus.flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_adv        = ~r_out_valid | bus.out_ready;
   assign bus.in_ready = w_adv;

   assign w_aext = ((bus.in_op == 2'b01) || (bus.in_op == 2'b10)) & bus.in_src1[DATA_W-1];
   assign w_bext = (bus.in_op == 2'b01) & bus.in_src2[DATA_W-1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_v         <= '0;
         r_out_valid <= 1'b0;
      end else if (w_flush) begin
         r_v         <= '0;
         r_out_valid <= 1'b0;
      end else if (w_adv) begin
         r_v[0] <= bus.in_valid;
         for (int s = 1; s < c_nst; s++) begin
            r_v[s] <= r_v[s-1];
         end
         r_out_valid <= r_v[c_nst-1];
      end
   end

   // Datapath registers carry no reset; only the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (w_adv) begin
         r_a      <= bus.in_src1;
         r_b      <= bus.in_src2;
         r_aext   <= w_aext;
         r_bext   <= w_bext;
         r_op[0]  <= bus.in_op;
         r_tag[0] <= bus.in_tag;
         for (int s = 1; s < c_nst; s++) begin
            r_op[s]  <= r_op[s-1];
            r_tag[s] <= r_tag[s-1];
         end
      end
   end

   if (LATENCY == 2) begin : g_lat2
      terms_t w_t;
      assign w_t       = f_reduce(f_pp(r_a, r_b, r_aext, r_bext), c_nlev);
      assign w_product = w_t[0];
   end else begin : g_latn
      terms_t r_terms [1:LATENCY-2];
      terms_t w_t;

      always_ff @(posedge clk) begin
         if (w_adv) begin
            r_terms[1] <= f_pp(r_a, r_b, r_aext, r_bext);
            for (int k = 2; k <= LATENCY - 2; k++) begin
               r_terms[k] <= f_reduce(r_terms[k-1], f_done(k) - f_done(k-1));
            end
         end
      end

      assign w_t       = f_reduce(r_terms[LATENCY-2], c_nlev - f_done(LATENCY - 2));
      assign w_product = w_t[0];
   end

   assign w_sel = (r_op[c_nst-1] == 2'b00) ? w_product[DATA_W-1:0]
                                           : w_product[c_pw-1:DATA_W];

   // Result and tag only move on a valid beat so a bubble leaves them intact.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_result <= '0;
         r_out_tag    <= '0;
      end else if (w_adv && r_v[c_nst-1] && !w_flush) begin
         r_out_result <= w_sel;
         r_out_tag    <= r_tag[c_nst-1];
      end
   end

   assign bus.out_valid  = r_out_valid;
   assign bus.out_result = r_out_result;
   assign bus.out_tag    = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_nios2_mult_pipe.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_nios2_mult_pipe                                                        |
// | Scoreboard bench for nios2_mult_pipe (DATA_W=32, LATENCY=3).              |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_nios2_mult_pipe;

   localparam int DATA_W  = 32;
   localparam int TAG_W   = 5;
   localparam int LATENCY = 3;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [TAG_W-1:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   exp_t sb[$];
   int   checks    = 0;
   int   errors    = 0;
   int   outs_seen = 0;

   always #5 clk = ~clk;

   nios2_mult_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

   nios2_mult_pipe #(
      .DATA_W (DATA_W),
      .PART_W (16),
      .LATENCY(LATENCY),
      .TAG_W  (TAG_W)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   function automatic logic [DATA_W-1:0] f_model(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic signed [DATA_W:0]     ea;
      logic signed [DATA_W:0]     eb;
      logic signed [2*DATA_W+1:0] p;
      ea = $signed({((op == 2'b01) || (op == 2'b10)) ? a[DATA_W-1] : 1'b0, a});
      eb = $signed({(op == 2'b01) ? b[DATA_W-1] : 1'b0, b});
      p  = ea * eb;
      return (op == 2'b00) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
   endfunction

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_op    = 2'b00;
      bus.in_src1  = '0;
      bus.in_src2  = '0;
      bus.in_tag   = '0;
   endtask

   // Presents one op from posedge+1 and pushes its expectation once accepted.
   task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag,
                       input logic [DATA_W-1:0] exp_res);
      int n;
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_src1  = a;
      bus.in_src2  = b;
      bus.in_tag   = tag;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout tag=%0d in_ready=%b required 1", tag, bus.in_ready);
      end else begin
         sb.push_back('{result: exp_res, tag: tag});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout pending=%0d required 0", sb.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.out_ready = 1'b1;
`ifdef NIOS2_MULT_PIPE_FLUSH_EN
      bus.flush     = 1'b0;
`endif
      idle();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got=%b required 1", bus.in_ready);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got=%b required 0", bus.out_valid);
      end
      checks++;
      if (bus.out_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_out_result got=%h required 00000000", bus.out_result);
      end
      checks++;
      if (bus.out_tag !== 5'd0) begin
         errors++;
         $display("FAIL reset_out_tag got=%0d required 0", bus.out_tag);
      end
   endtask

   task automatic test_ops();
      int k;
      send(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001);
      idle();
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      checks++;
      if (k != LATENCY) begin
         errors++;
         $display("FAIL mul_latency got=%0d required %0d", k, LATENCY);
      end
      @(posedge clk);
      #1;
      send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE);
      send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000);
      send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF);
      idle();
      drain();
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = outs_seen;
      for (int i = 0; i < 8; i++) begin
         send(2'b11, 32'h0001_0000, 32'h0001_0000, TAG_W'(i), 32'h0000_0001);
      end
      idle();
      checks++;
      if (outs_seen - n0 != 8 - LATENCY) begin
         errors++;
         $display("FAIL b2b_early_count got=%0d required %0d", outs_seen - n0, 8 - LATENCY);
      end
      for (int j = 0; j < LATENCY; j++) begin
         @(negedge clk);
         checks++;
         if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stream_gap cycle=%0d out_valid=%b required 1", j, bus.out_valid);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_tail out_valid=%b required 0", bus.out_valid);
      end
      @(posedge clk);
      #1;
      drain();
   endtask

   task automatic test_backpressure();
      logic [DATA_W-1:0] a [LATENCY];
      logic [DATA_W-1:0] b [LATENCY];
      logic [DATA_W-1:0] exp0;
      int                n0;
      for (int i = 0; i < LATENCY; i++) begin
         a[i] = 32'hDEAD_0000 + DATA_W'(i * 977);
         b[i] = 32'h8765_4321 ^ DATA_W'(i << 28);
      end
      exp0 = f_model(2'b01, a[0], b[0]);
      bus.out_ready = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         send(2'b01, a[i], b[i], TAG_W'(10 + i), f_model(2'b01, a[i], b[i]));
      end
      idle();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stall cycle=%0d in_ready=%b out_valid=%b required 0/1",
                     c, bus.in_ready, bus.out_valid);
         end
         checks++;
         if (bus.out_result !== exp0 || bus.out_tag !== 5'd10) begin
            errors++;
            $display("FAIL bp_hold cycle=%0d result=%h tag=%0d required %h/10",
                     c, bus.out_result, bus.out_tag, exp0);
         end
      end
      @(posedge clk);
      #1;
      n0 = outs_seen;
      bus.out_ready = 1'b1;
      drain();
      checks++;
      if (outs_seen - n0 != LATENCY) begin
         errors++;
         $display("FAIL bp_release_count got=%0d required %0d", outs_seen - n0, LATENCY);
      end
   endtask

   task automatic test_reset_flight();
      int n0;
      for (int i = 0; i < 3; i++) begin
         send(2'b00, 32'h1234_5678 + DATA_W'(i), 32'h0000_0100, TAG_W'(20 + i),
              f_model(2'b00, 32'h1234_5678 + DATA_W'(i), 32'h0000_0100));
      end
      idle();
      reset = 1'b1;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_async out_valid=%b required 0", bus.out_valid);
      end
      sb.delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      n0 = outs_seen;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (outs_seen != n0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_stale outputs=%0d out_valid=%b required 0/0",
                  outs_seen - n0, bus.out_valid);
      end
      send(2'b00, 32'd7, 32'd6, 5'd23, 32'd42);
      idle();
      drain();
      checks++;
      if (outs_seen - n0 != 1) begin
         errors++;
         $display("FAIL rst_next_count got=%0d required 1", outs_seen - n0);
      end
   endtask

`ifdef NIOS2_MULT_PIPE_FLUSH_EN
   task automatic test_flush();
      int                k;
      int                n0;
      logic [DATA_W-1:0] exp_r;
      n0    = outs_seen;
      exp_r = f_model(2'b01, 32'hFFFF_FFF9, 32'h0000_0013);
      send(2'b10, 32'h8000_0003, 32'h0000_0005, 5'd24, 32'h0);
      send(2'b10, 32'h7000_0003, 32'h0000_0009, 5'd25, 32'h0);
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_tag   = 5'd26;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_in_ready got=%b required 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      sb.delete();
      send(2'b01, 32'hFFFF_FFF9, 32'h0000_0013, 5'd27, exp_r);
      idle();
      for (k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.out_valid) break;
      end
      checks++;
      if (k != LATENCY || bus.out_tag !== 5'd27 || bus.out_result !== exp_r) begin
         errors++;
         $display("FAIL flush_next latency=%0d tag=%0d result=%h required %0d/27/%h",
                  k, bus.out_tag, bus.out_result, LATENCY, exp_r);
      end
      @(posedge clk);
      #1;
      drain();
      checks++;
      if (outs_seen - n0 != 1) begin
         errors++;
         $display("FAIL flush_count got=%0d required 1", outs_seen - n0);
      end
   endtask
`endif

   initial begin
      exp_t e;
      fork
         forever begin
            @(negedge clk);
            if (!reset && bus.out_valid && bus.out_ready) begin
               outs_seen++;
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL sb_unexpected result=%h tag=%0d required none",
                           bus.out_result, bus.out_tag);
               end else begin
                  e = sb.pop_front();
                  if (bus.out_result !== e.result || bus.out_tag !== e.tag) begin
                     errors++;
                     $display("FAIL sb_result got=%h tag=%0d required %h tag=%0d",
                              bus.out_result, bus.out_tag, e.result, e.tag);
                  end
               end
            end
         end
         begin
            #500000;
            $display("FAIL watchdog_timeout");
            $fatal(1, "watchdog");
         end
      join_none

      test_reset();
      test_ops();
      test_back_to_back();
      test_backpressure();
      test_reset_flight();
`ifdef NIOS2_MULT_PIPE_FLUSH_EN
      test_flush();
`endif
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover pending=%0d required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
